// File: rtl/mips_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit and the decoder that feeds it.
package mips_muldiv_pkg;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Divide datapath is present only when MIPS_MULDIV_DIV_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO/illegal complete here in one cycle
// RUN   | one shift-add or restoring-divide step per cycle, cnt counts down
// FIX   | sign correction, HI/LO write, done pulse
module mips_muldiv
   import mips_muldiv_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] HILO_INIT = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  muldiv_op_t       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             illegal_op,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   muldiv_state_t      state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   operand;
   logic               sa;
   logic               sb;

   logic               op_signed;
   logic               s_rs;
   logic               s_rt;
   logic [WIDTH-1:0]   mag_rs;
   logic [WIDTH-1:0]   mag_rt;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] product;

   assign op_signed = (op == MULT) || (op == DIV);
   assign s_rs      = op_signed & rs_data[WIDTH-1];
   assign s_rt      = op_signed & rt_data[WIDTH-1];
   assign mag_rs    = s_rs ? -rs_data : rs_data;
   assign mag_rt    = s_rt ? -rt_data : rt_data;

   // acc = {partial product, remaining multiplier bits}
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
   assign product = (sa ^ sb) ? -acc : acc;

`ifdef MIPS_MULDIV_DIV_EN
   logic             is_div;
   logic             dbz_q;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   // acc = {remainder, dividend bits shifting into quotient}
   assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
   assign trial    = rem_sh - {1'b0, operand};
   assign quot_fix = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   // A zero divisor leaves |a| in the remainder, so this also restores rs_data.
   assign rem_fix  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         acc        <= '0;
         operand    <= '0;
         sa         <= 1'b0;
         sb         <= 1'b0;
         hi         <= HILO_INIT;
         lo         <= HILO_INIT;
         busy       <= 1'b0;
         done       <= 1'b0;
         illegal_op <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
         is_div      <= 1'b0;
         dbz_q       <= 1'b0;
         div_by_zero <= 1'b0;
`endif
      end else begin
         done       <= 1'b0;
         illegal_op <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
         div_by_zero <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     MULT, MULTU: begin
                        acc     <= {{WIDTH{1'b0}}, mag_rt};
                        operand <= mag_rs;
                        sa      <= s_rs;
                        sb      <= s_rt;
                        cnt     <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        state   <= RUN;
`ifdef MIPS_MULDIV_DIV_EN
                        is_div  <= 1'b0;
                        dbz_q   <= 1'b0;
`endif
                     end
`ifdef MIPS_MULDIV_DIV_EN
                     DIV, DIVU: begin
                        acc     <= {{WIDTH{1'b0}}, mag_rs};
                        operand <= mag_rt;
                        sa      <= s_rs;
                        sb      <= s_rt;
                        cnt     <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        is_div  <= 1'b1;
                        dbz_q   <= (rt_data == '0);
                        state   <= RUN;
                     end
`endif
                     MTHI: begin
                        hi   <= rs_data;
                        done <= 1'b1;
                     end
                     MTLO: begin
                        lo   <= rs_data;
                        done <= 1'b1;
                     end
                     default: begin
                        illegal_op <= 1'b1;
                        done       <= 1'b1;
                     end
                  endcase
               end
            end

            RUN: begin
`ifdef MIPS_MULDIV_DIV_EN
               if (is_div) begin
                  if (trial[WIDTH])
                     acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                  else
                     acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               end
`else
               acc <= {mul_sum, acc[WIDTH-1:1]};
`endif
               if (cnt == '0)
                  state <= FIX;
               else
                  cnt <= cnt - 1'b1;
            end

            FIX: begin
`ifdef MIPS_MULDIV_DIV_EN
               if (is_div) begin
                  hi          <= rem_fix;
                  lo          <= dbz_q ? {WIDTH{1'b1}} : quot_fix;
                  div_by_zero <= dbz_q;
               end else begin
                  hi <= product[2*WIDTH-1:WIDTH];
                  lo <= product[WIDTH-1:0];
               end
`else
               hi <= product[2*WIDTH-1:WIDTH];
               lo <= product[WIDTH-1:0];
`endif
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: arithmetic reference model plus hand-computed vectors.
module tb_mips_muldiv;
   import mips_muldiv_pkg::*;

   localparam int          W    = 32;
   localparam logic [31:0] INIT = 32'h5A5A_C3C3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   muldiv_op_t  op_i = MULT;
   logic [31:0] rs = '0;
   logic [31:0] rt = '0;
   logic        busy, done, div_by_zero, illegal_op;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   mips_muldiv #(.WIDTH(W), .HILO_INIT(INIT)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op_i),
      .rs_data(rs), .rt_data(rt),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .illegal_op(illegal_op),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: results from plain arithmetic, delivered W+1 cycles after accept.
   logic        model_valid = 1'b0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, m_ill = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        p_dbz = 1'b0;
   int          m_left = 0;

   always @(posedge clk) begin
      longint      sa64, sb64, sp;
      logic [63:0] up;
      if (reset) begin
         model_valid = 1'b1;
         m_busy = 0; m_done = 0; m_dbz = 0; m_ill = 0; m_left = 0;
         m_hi = INIT; m_lo = INIT;
      end else begin
         m_done = 0; m_dbz = 0; m_ill = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1;
               m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
            end
         end else if (start) begin
            sa64 = longint'($signed(rs));
            sb64 = longint'($signed(rt));
            p_dbz = 0;
            case (op_i)
               MULT: begin
                  sp = sa64 * sb64;
                  p_hi = sp[63:32]; p_lo = sp[31:0];
                  m_busy = 1; m_left = W + 1;
               end
               MULTU: begin
                  up = {32'b0, rs} * {32'b0, rt};
                  p_hi = up[63:32]; p_lo = up[31:0];
                  m_busy = 1; m_left = W + 1;
               end
`ifdef MIPS_MULDIV_DIV_EN
               DIV, DIVU: begin
                  if (rt == 0) begin
                     p_lo = 32'hFFFF_FFFF; p_hi = rs; p_dbz = 1;
                  end else if (op_i == DIV) begin
                     sp = sa64 / sb64; p_lo = sp[31:0];
                     sp = sa64 % sb64; p_hi = sp[31:0];
                  end else begin
                     p_lo = rs / rt; p_hi = rs % rt;
                  end
                  m_busy = 1; m_left = W + 1;
               end
`endif
               MTHI: begin m_hi = rs; m_done = 1; end
               MTLO: begin m_lo = rs; m_done = 1; end
               default: begin m_ill = 1; m_done = 1; end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("busy", {63'b0, busy}, {63'b0, m_busy});
         check("done", {63'b0, done}, {63'b0, m_done});
         check("div_by_zero", {63'b0, div_by_zero}, {63'b0, m_dbz});
         check("illegal_op", {63'b0, illegal_op}, {63'b0, m_ill});
         check("hi", {32'b0, hi}, {32'b0, m_hi});
         check("lo", {32'b0, lo}, {32'b0, m_lo});
      end
   end

   task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op_i = o; rs = a; rt = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   typedef struct { muldiv_op_t o; logic [31:0] a; logic [31:0] b; } vec_t;
   vec_t extra[6];

   initial begin
      int done_seen;
      extra[0] = '{MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF};
      extra[1] = '{MULT,  32'h8000_0000, 32'h8000_0000};
      extra[2] = '{MULTU, 32'h1234_5678, 32'h9ABC_DEF0};
      extra[3] = '{DIV,   32'd100,       32'hFFFF_FFF9};
      extra[4] = '{DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9};
      extra[5] = '{DIVU,  32'hFFFF_FFFF, 32'd3};

      repeat (3) @(negedge clk);
      check("reset_hi", {32'b0, hi}, {32'b0, INIT});
      check("reset_lo", {32'b0, lo}, {32'b0, INIT});
      check("reset_busy", {63'b0, busy}, 64'd0);
      reset = 1'b0;

      issue(MULT, 32'hFFFF_FFFD, 32'h0000_0005);
      repeat (W + 1) @(negedge clk);
      check("mult_done", {63'b0, done}, 64'd1);
      check("mult_hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
      check("mult_lo", {32'b0, lo}, 64'h0000_0000_FFFF_FFF1);

      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (W + 1) @(negedge clk);
      check("multu_hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFE);
      check("multu_lo", {32'b0, lo}, 64'h0000_0000_0000_0001);

      issue(MTLO, 32'h1234_5678, 32'h0);
      check("mtlo_lo", {32'b0, lo}, 64'h0000_0000_1234_5678);
      check("mtlo_hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFE);
      check("mtlo_done", {63'b0, done}, 64'd1);
      issue(MTHI, 32'h0BAD_F00D, 32'h0);
      check("mthi_hi", {32'b0, hi}, 64'h0000_0000_0BAD_F00D);

`ifdef MIPS_MULDIV_DIV_EN
      issue(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      repeat (W + 1) @(negedge clk);
      check("div_lo", {32'b0, lo}, 64'h0000_0000_FFFF_FFFD);
      check("div_hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      repeat (W + 1) @(negedge clk);
      check("divovf_lo", {32'b0, lo}, 64'h0000_0000_8000_0000);
      check("divovf_hi", {32'b0, hi}, 64'd0);
      issue(DIVU, 32'h0000_0007, 32'h0);
      repeat (W + 1) @(negedge clk);
      check("dbz_lo", {32'b0, lo}, 64'h0000_0000_FFFF_FFFF);
      check("dbz_hi", {32'b0, hi}, 64'h0000_0000_0000_0007);
      check("dbz_flag", {63'b0, div_by_zero}, 64'd1);
`else
      issue(DIVU, 32'h0000_0007, 32'h0);
      check("nodiv_illegal", {63'b0, illegal_op}, 64'd1);
      check("nodiv_busy", {63'b0, busy}, 64'd0);
      check("nodiv_hi", {32'b0, hi}, 64'h0000_0000_0BAD_F00D);
      check("nodiv_lo", {32'b0, lo}, 64'h0000_0000_1234_5678);
      issue(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      check("nodiv2_illegal", {63'b0, illegal_op}, 64'd1);
`endif

      issue(muldiv_op_t'(3'd6), 32'h1111_1111, 32'h2222_2222);
      check("illegal_flag", {63'b0, illegal_op}, 64'd1);
      check("illegal_lo", {32'b0, lo}, {32'b0, m_lo});

      // Starts while busy are dropped; a start in the done cycle is taken.
      issue(MULTU, 32'd3, 32'd4);
      repeat (5) @(negedge clk);
      start = 1'b1; op_i = MTHI; rs = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (W + 1 - 8) @(negedge clk);
      check("b2b_first_done", {63'b0, done}, 64'd1);
      check("b2b_first_hi", {32'b0, hi}, 64'd0);
      check("b2b_first_lo", {32'b0, lo}, 64'd12);
      start = 1'b1; op_i = MULT; rs = 32'd7; rt = 32'hFFFF_FFFE;
      @(negedge clk);
      start = 1'b0;
      check("b2b_accept_busy", {63'b0, busy}, 64'd1);
      repeat (W + 1) @(negedge clk);
      check("b2b_second_done", {63'b0, done}, 64'd1);
      check("b2b_second_hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
      check("b2b_second_lo", {32'b0, lo}, 64'h0000_0000_FFFF_FFF2);

      foreach (extra[i]) begin
         issue(extra[i].o, extra[i].a, extra[i].b);
         repeat (W + 1) @(negedge clk);
      end

      // Reset during RUN aborts the multiply.
      issue(MULT, 32'h0000_1234, 32'h0000_5678);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_hi", {32'b0, hi}, {32'b0, INIT});
      check("abort_lo", {32'b0, lo}, {32'b0, INIT});
      reset = 1'b0;
      done_seen = 0;
      repeat (W + 8) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
